// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with pixel enable, run control and line/frame strobes
//
// Purpose:
//    Generates HSYNC/VSYNC, an active-video qualifier and 0-based pixel
//    column/row addresses for any mode described by sync, back porch,
//    active and front porch parameters. Line order is sync, back porch,
//    active, front porch, both horizontally and vertically.
//    All state advances only on CLK edges where Pix_En=1. Every output is a
//    register loaded from the decode of the counters' next value, so sync,
//    Ready_Sig and the addresses always describe the current counter state.
//
// Ports:
//    CLK              in   system clock
//    RSTn             in   asynchronous active-low reset
//    Pix_En           in   pixel tick qualifier
//    Enable           in   run control, sampled on Pix_En ticks; 0 parks the generator
//    HSYNC_Sig        out  horizontal sync, active level HS_POL
//    VSYNC_Sig        out  vertical sync, active level VS_POL
//    Ready_Sig        out  active-video region
//    Column_Addr_Sig  out  x address inside the active area, 0 elsewhere
//    Row_Addr_Sig     out  y address inside the active area, 0 elsewhere
//    Line_Start_Sig   out  one-CLK strobe when the horizontal counter wraps to 0
//    Frame_Start_Sig  out  one-CLK strobe when the position enters (0,0)
//
// Build option:
//    VGA_TIMING_LOOKAHEAD_EN - when defined, Column_Addr_Sig/Row_Addr_Sig
//    lead Ready_Sig by one Pix_En tick so a 1-cycle synchronous RAM read
//    lines up with the active-video qualifier. Syncs and strobes unchanged.

module vga_timing_gen #(
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int ADDR_W   = 11
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              Pix_En,
   input  logic              Enable,
   output logic              HSYNC_Sig,
   output logic              VSYNC_Sig,
   output logic              Ready_Sig,
   output logic [ADDR_W-1:0] Column_Addr_Sig,
   output logic [ADDR_W-1:0] Row_Addr_Sig,
   output logic              Line_Start_Sig,
   output logic              Frame_Start_Sig
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam int H_ACT_BEG = H_SYNC + H_BP;
   localparam int H_ACT_END = H_ACT_BEG + H_ACTIVE;
   localparam int V_ACT_BEG = V_SYNC + V_BP;
   localparam int V_ACT_END = V_ACT_BEG + V_ACTIVE;

   // Parked position: one step before (0,0), so the first tick after reset
   // or re-enable lands on the frame origin and fires both strobes.
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   // Counter and output registers
   logic [HW-1:0]     h_q, h_d;
   logic [VW-1:0]     v_q, v_d;
   logic              hs_q, hs_d;
   logic              vs_q, vs_d;
   logic              rdy_q, rdy_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic              ls_q, ls_d;
   logic              fs_q, fs_d;

   // Position stepping: h wraps at H_TOTAL-1, v advances only on the h wrap.
   function automatic logic [HW-1:0] h_adv(input logic [HW-1:0] h);
      return (h == H_LAST) ? '0 : h + HW'(1);
   endfunction

   function automatic logic [VW-1:0] v_adv(input logic [HW-1:0] h, input logic [VW-1:0] v);
      if (h != H_LAST) begin
         return v;
      end
      return (v == V_LAST) ? '0 : v + VW'(1);
   endfunction

   // Region decode. Comparisons are done in int so an end bound equal to
   // the total (zero front porch) still fits.
   function automatic logic h_active(input logic [HW-1:0] h);
      return (int'(h) >= H_ACT_BEG) && (int'(h) < H_ACT_END);
   endfunction

   function automatic logic v_active(input logic [VW-1:0] v);
      return (int'(v) >= V_ACT_BEG) && (int'(v) < V_ACT_END);
   endfunction

   function automatic logic [ADDR_W-1:0] col_of(input logic [HW-1:0] h);
      return ADDR_W'(int'(h) - H_ACT_BEG);
   endfunction

   function automatic logic [ADDR_W-1:0] row_of(input logic [VW-1:0] v);
      return ADDR_W'(int'(v) - V_ACT_BEG);
   endfunction

`ifdef VGA_TIMING_LOOKAHEAD_EN
   // Position one tick beyond the one being loaded; addresses decode here.
   logic [HW-1:0] h_la;
   logic [VW-1:0] v_la;
   logic          la_active;
`endif

   always_comb begin
      h_d   = h_q;
      v_d   = v_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      rdy_d = rdy_q;
      col_d = col_q;
      row_d = row_q;
      // Strobes are one CLK wide: cleared on every edge that is not a tick.
      ls_d  = 1'b0;
      fs_d  = 1'b0;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      h_la      = h_adv(h_q);
      v_la      = v_adv(h_q, v_q);
      la_active = 1'b0;
`endif

      if (Pix_En) begin
         if (!Enable) begin
            // Park: counters one step before origin, outputs at reset values.
            h_d   = H_LAST;
            v_d   = V_LAST;
            hs_d  = ~HS_POL;
            vs_d  = ~VS_POL;
            rdy_d = 1'b0;
            col_d = '0;
            row_d = '0;
         end else begin
            h_d   = h_adv(h_q);
            v_d   = v_adv(h_q, v_q);
            hs_d  = (int'(h_d) < H_SYNC) ? HS_POL : ~HS_POL;
            vs_d  = (int'(v_d) < V_SYNC) ? VS_POL : ~VS_POL;
            rdy_d = h_active(h_d) && v_active(v_d);
`ifdef VGA_TIMING_LOOKAHEAD_EN
            h_la      = h_adv(h_d);
            v_la      = v_adv(h_d, v_d);
            la_active = h_active(h_la) && v_active(v_la);
            col_d     = la_active ? col_of(h_la) : '0;
            row_d     = la_active ? row_of(v_la) : '0;
`else
            col_d = rdy_d ? col_of(h_d) : '0;
            row_d = rdy_d ? row_of(v_d) : '0;
`endif
            ls_d  = (h_d == '0);
            fs_d  = (h_d == '0) && (v_d == '0);
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         h_q   <= H_LAST;
         v_q   <= V_LAST;
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         rdy_q <= 1'b0;
         col_q <= '0;
         row_q <= '0;
         ls_q  <= 1'b0;
         fs_q  <= 1'b0;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         rdy_q <= rdy_d;
         col_q <= col_d;
         row_q <= row_d;
         ls_q  <= ls_d;
         fs_q  <= fs_d;
      end
   end

   assign HSYNC_Sig       = hs_q;
   assign VSYNC_Sig       = vs_q;
   assign Ready_Sig       = rdy_q;
   assign Column_Addr_Sig = col_q;
   assign Row_Addr_Sig    = row_q;
   assign Line_Start_Sig  = ls_q;
   assign Frame_Start_Sig = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against a position-arithmetic model
module tb_vga_timing_gen;

   localparam int ND = 3;

   logic CLK    = 1'b0;
   logic RSTn   = 1'b0;
   logic Pix_En = 1'b0;
   logic Enable = 1'b0;

   always #5 CLK = ~CLK;

   typedef struct packed {
      int hs; int hbp; int ha; int hfp;
      int vs; int vbp; int va; int vfp;
      bit hpol; bit vpol;
   } cfg_t;

   logic        hs_w  [ND];
   logic        vs_w  [ND];
   logic        rd_w  [ND];
   logic [10:0] col_w [ND];
   logic [10:0] row_w [ND];
   logic        ls_w  [ND];
   logic        fs_w  [ND];
   logic [26:0] obs   [ND];

   // dut0: tiny mode, dut1: 640x480 with active-high syncs, dut2: defaults
   vga_timing_gen #(
      .H_SYNC(3), .H_BP(2), .H_ACTIVE(6), .H_FP(2),
      .V_SYNC(2), .V_BP(2), .V_ACTIVE(4), .V_FP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .ADDR_W(11)
   ) u_small (
      .CLK(CLK), .RSTn(RSTn), .Pix_En(Pix_En), .Enable(Enable),
      .HSYNC_Sig(hs_w[0]), .VSYNC_Sig(vs_w[0]), .Ready_Sig(rd_w[0]),
      .Column_Addr_Sig(col_w[0]), .Row_Addr_Sig(row_w[0]),
      .Line_Start_Sig(ls_w[0]), .Frame_Start_Sig(fs_w[0])
   );

   vga_timing_gen #(
      .H_SYNC(96), .H_BP(48), .H_ACTIVE(640), .H_FP(16),
      .V_SYNC(2), .V_BP(33), .V_ACTIVE(480), .V_FP(10),
      .HS_POL(1'b1), .VS_POL(1'b1), .ADDR_W(11)
   ) u_vga (
      .CLK(CLK), .RSTn(RSTn), .Pix_En(Pix_En), .Enable(Enable),
      .HSYNC_Sig(hs_w[1]), .VSYNC_Sig(vs_w[1]), .Ready_Sig(rd_w[1]),
      .Column_Addr_Sig(col_w[1]), .Row_Addr_Sig(row_w[1]),
      .Line_Start_Sig(ls_w[1]), .Frame_Start_Sig(fs_w[1])
   );

   vga_timing_gen u_def (
      .CLK(CLK), .RSTn(RSTn), .Pix_En(Pix_En), .Enable(Enable),
      .HSYNC_Sig(hs_w[2]), .VSYNC_Sig(vs_w[2]), .Ready_Sig(rd_w[2]),
      .Column_Addr_Sig(col_w[2]), .Row_Addr_Sig(row_w[2]),
      .Line_Start_Sig(ls_w[2]), .Frame_Start_Sig(fs_w[2])
   );

   assign obs[0] = {hs_w[0], vs_w[0], rd_w[0], col_w[0], row_w[0], ls_w[0], fs_w[0]};
   assign obs[1] = {hs_w[1], vs_w[1], rd_w[1], col_w[1], row_w[1], ls_w[1], fs_w[1]};
   assign obs[2] = {hs_w[2], vs_w[2], rd_w[2], col_w[2], row_w[2], ls_w[2], fs_w[2]};

   int n_cmp = 0;
   int n_bad = 0;

   // Model: n counts pixel ticks since the frame origin (-1 = parked);
   // expected outputs are derived from n with division and modulo.
   longint      n_m   [ND];
   logic [26:0] exp_m [ND];

   function automatic cfg_t cfg_of(input int d);
      cfg_t c;
      case (d)
         0:       c = '{hs:3,   hbp:2,  ha:6,   hfp:2,  vs:2, vbp:2,  va:4,   vfp:1,  hpol:1'b0, vpol:1'b0};
         1:       c = '{hs:96,  hbp:48, ha:640, hfp:16, vs:2, vbp:33, va:480, vfp:10, hpol:1'b1, vpol:1'b1};
         default: c = '{hs:128, hbp:88, ha:800, hfp:40, vs:4, vbp:23, va:600, vfp:1,  hpol:1'b0, vpol:1'b0};
      endcase
      return c;
   endfunction

   function automatic logic [26:0] reset_vec(input cfg_t c);
      return {~c.hpol, ~c.vpol, 1'b0, 11'd0, 11'd0, 2'b00};
   endfunction

   function automatic bit in_act(input cfg_t c, input int h, input int v);
      return (h >= c.hs + c.hbp) && (h < c.hs + c.hbp + c.ha) &&
             (v >= c.vs + c.vbp) && (v < c.vs + c.vbp + c.va);
   endfunction

   function automatic logic [26:0] decode(input cfg_t c, input longint n);
      int ht, vt, h, v, hn, vn;
      bit act, actn;
      logic [10:0] col, row;
      ht   = c.hs + c.hbp + c.ha + c.hfp;
      vt   = c.vs + c.vbp + c.va + c.vfp;
      h    = int'(n % ht);
      v    = int'((n / ht) % vt);
      hn   = int'((n + 1) % ht);
      vn   = int'(((n + 1) / ht) % vt);
      act  = in_act(c, h, v);
      actn = in_act(c, hn, vn);
`ifdef VGA_TIMING_LOOKAHEAD_EN
      col = actn ? 11'(hn - c.hs - c.hbp) : 11'd0;
      row = actn ? 11'(vn - c.vs - c.vbp) : 11'd0;
`else
      col = act ? 11'(h - c.hs - c.hbp) : 11'd0;
      row = act ? 11'(v - c.vs - c.vbp) : 11'd0;
      if (actn) col = col;
`endif
      return {(h < c.hs) ? c.hpol : ~c.hpol, (v < c.vs) ? c.vpol : ~c.vpol,
              act, col, row, (h == 0), (h == 0) && (v == 0)};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         n_m[d]   = -1;
         exp_m[d] = reset_vec(cfg_of(d));
      end
   endtask

   // Drive one CLK of stimulus and advance the model; ends on the negedge.
   task automatic tick(input bit pix, input bit en);
      Pix_En = pix;
      Enable = en;
      @(posedge CLK);
      for (int d = 0; d < ND; d++) begin
         if (!RSTn) begin
            n_m[d]   = -1;
            exp_m[d] = reset_vec(cfg_of(d));
         end else if (!pix) begin
            exp_m[d][1:0] = 2'b00;
         end else if (!en) begin
            n_m[d]   = -1;
            exp_m[d] = reset_vec(cfg_of(d));
         end else begin
            n_m[d]   = n_m[d] + 1;
            exp_m[d] = decode(cfg_of(d), n_m[d]);
         end
      end
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1);
         for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (obs[d] !== exp_m[d]) begin
               n_bad++;
               $display("FAIL reset dut%0d cyc%0d: got %h want %h", d, i, obs[d], exp_m[d]);
            end
         end
      end
   endtask

   task automatic test_free_run();
      int hs_low_def, hs_high_vga, vs_high_vga;
      int ls_def [$];
      int fs_small [$];
      int first_col;
      first_col   = -1;
      hs_low_def  = 0;
      hs_high_vga = 0;
      vs_high_vga = 0;
      RSTn = 1'b1;
      for (int i = 0; i < 2600; i++) begin
         tick(1'b1, 1'b1);
         for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (obs[d] !== exp_m[d]) begin
               n_bad++;
               $display("FAIL free_run dut%0d cyc%0d: got %h want %h", d, i, obs[d], exp_m[d]);
            end
         end
         if (i < 1056 && hs_w[2] == 1'b0) hs_low_def++;
         if (i < 800 && hs_w[1] == 1'b1) hs_high_vga++;
         if (i < 2400 && vs_w[1] == 1'b1) vs_high_vga++;
         if (ls_w[2]) ls_def.push_back(i);
         if (fs_w[0]) fs_small.push_back(i);
         if (first_col < 0 && rd_w[0]) first_col = int'(col_w[0]);
      end
      n_cmp++;
      if (hs_low_def != 128) begin
         n_bad++;
         $display("FAIL def_hsync_low: got %0d want 128", hs_low_def);
      end
      n_cmp++;
      if (ls_def.size() < 2 || ls_def[0] != 0 || ls_def[1] != 1056) begin
         n_bad++;
         $display("FAIL def_line_period: got %0d strobes first %0d want at 0 and 1056", ls_def.size(),
                  (ls_def.size() > 0) ? ls_def[0] : -1);
      end
      n_cmp++;
      if (hs_high_vga != 96) begin
         n_bad++;
         $display("FAIL vga_hsync_high: got %0d want 96", hs_high_vga);
      end
      n_cmp++;
      if (vs_high_vga != 1600) begin
         n_bad++;
         $display("FAIL vga_vsync_high: got %0d want 1600", vs_high_vga);
      end
      n_cmp++;
      if (fs_small.size() < 3 || fs_small[1] - fs_small[0] != 117 || fs_small[0] != 0) begin
         n_bad++;
         $display("FAIL small_frame_period: got %0d strobes want period 117 from 0", fs_small.size());
      end
      n_cmp++;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      if (first_col != 1) begin
         n_bad++;
         $display("FAIL first_ready_col: got %0d want 1", first_col);
      end
`else
      if (first_col != 0) begin
         n_bad++;
         $display("FAIL first_ready_col: got %0d want 0", first_col);
      end
`endif
   endtask

   task automatic test_pix_toggle();
      int fs_at [$];
      tick(1'b1, 1'b0);
      for (int i = 0; i < 600; i++) begin
         tick((i % 2) == 0, 1'b1);
         for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (obs[d] !== exp_m[d]) begin
               n_bad++;
               $display("FAIL pix_toggle dut%0d cyc%0d: got %h want %h", d, i, obs[d], exp_m[d]);
            end
         end
         if (fs_w[0]) fs_at.push_back(i);
      end
      n_cmp++;
      if (fs_at.size() < 2 || fs_at[1] - fs_at[0] != 234) begin
         n_bad++;
         $display("FAIL toggle_frame_period: got %0d strobes want period 234", fs_at.size());
      end
   endtask

   task automatic test_enable_drop();
      int guard;
      guard = 0;
      // run the small mode to an active pixel mid-frame (v=4, h=7)
      while (!(n_m[0] >= 0 && (n_m[0] % 13) == 7 && ((n_m[0] / 13) % 9) == 4) && guard < 300) begin
         tick(1'b1, 1'b1);
         guard++;
      end
      n_cmp++;
      if (rd_w[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL drop_precondition: ready got %b want 1 (guard %0d)", rd_w[0], guard);
      end
      for (int i = 0; i < 4; i++) begin
         tick((i != 1), 1'b0);
         for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (obs[d] !== reset_vec(cfg_of(d))) begin
               n_bad++;
               $display("FAIL enable_drop dut%0d cyc%0d: got %h want %h", d, i, obs[d], reset_vec(cfg_of(d)));
            end
         end
      end
      tick(1'b1, 1'b1);
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (obs[d] !== decode(cfg_of(d), 0)) begin
            n_bad++;
            $display("FAIL reenable dut%0d: got %h want %h", d, obs[d], decode(cfg_of(d), 0));
         end
      end
   endtask

   task automatic test_random();
      bit pix, en;
      for (int i = 0; i < 3000; i++) begin
         pix = ($urandom_range(0, 2) != 0);
         en  = ($urandom_range(0, 99) > 2);
         tick(pix, en);
         for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (obs[d] !== exp_m[d]) begin
               n_bad++;
               $display("FAIL random dut%0d cyc%0d: got %h want %h", d, i, obs[d], exp_m[d]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
      #2;
      RSTn = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < ND; d++) begin
         n_cmp++;
         if (obs[d] !== exp_m[d]) begin
            n_bad++;
            $display("FAIL async_reset dut%0d: got %h want %h", d, obs[d], exp_m[d]);
         end
      end
      @(negedge CLK);
      tick(1'b1, 1'b1);
      RSTn = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick(1'b1, 1'b1);
         for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (obs[d] !== exp_m[d]) begin
               n_bad++;
               $display("FAIL post_reset dut%0d cyc%0d: got %h want %h", d, i, obs[d], exp_m[d]);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      @(negedge CLK);
      test_reset();
      test_free_run();
      test_pix_toggle();
      test_enable_drop();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and the next-generation core of the VGA display path. It produces HSYNC/VSYNC with configurable polarity, an active-video qualifier, and pixel column/row addresses for any mode defined by porch, sync and active parameters. It also adds pixel-clock-enable operation, a run/stop control, and frame/line start strobes. It sits between the pixel clock domain and the pixel-source or framebuffer logic.

## Interface
- H_SYNC, 128, horizontal sync width in pixels
- H_BP, 88, horizontal back porch
- H_ACTIVE, 800, horizontal active pixels
- H_FP, 40, horizontal front porch
- V_SYNC, 4, vertical sync width in lines
- V_BP, 23, vertical back porch
- V_ACTIVE, 600, active lines
- V_FP, 1, vertical front porch
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level
- ADDR_W, 11, width of address outputs; must hold H_ACTIVE-1 and V_ACTIVE-1
- CLK  in  1  system clock
- RSTn  in  1  reset, asynchronous, active-low
- Pix_En  in  1  pixel tick; all state advances only on CLK edges with Pix_En=1
- Enable  in  1  run control; 0 parks the generator
- HSYNC_Sig  out  1  horizontal sync
- VSYNC_Sig  out  1  vertical sync
- Ready_Sig  out  1  active-video region
- Column_Addr_Sig  out  ADDR_W  x address, 0-based within active area
- Row_Addr_Sig  out  ADDR_W  y address, 0-based
- Line_Start_Sig  out  1  one-CLK strobe when h wraps to 0
- Frame_Start_Sig  out  1  one-CLK strobe when (h,v) enters (0,0)

## Operation
- Derived totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Defaults give 1056 x 628 (800x600@60, 40 MHz).
- Counter widths are $clog2(H_TOTAL) and $clog2(V_TOTAL).
- Line order is sync, back porch, active, front porch. The same order applies vertically.
- Counter h counts 0..H_TOTAL-1 and wraps to 0. Counter v increments only on the h wrap and itself wraps at V_TOTAL-1.
- Sync decode:
  - HSYNC is at HS_POL while h < H_SYNC; otherwise it is at ~HS_POL.
  - VSYNC is at VS_POL while v < V_SYNC; otherwise it is at ~VS_POL.
- Active region: h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE). With defaults this is h 216..1015 and v 27..626.
- Address outputs:
  - Column_Addr_Sig = h-(H_SYNC+H_BP) and Row_Addr_Sig = v-(V_SYNC+V_BP) inside the active region.
  - Both hold 0 outside the active region.
- Registered outputs:
  - Every output is a register loaded from the decode of the counters' next value.
  - As a result, the outputs always describe the current counter state. There is no skew between sync, Ready_Sig and the addresses.
- Reset state:
  - Counters reset to (H_TOTAL-1, V_TOTAL-1).
  - Sync outputs reset to their inactive level; Ready_Sig, addresses and strobes reset to 0.
  - The first Pix_En after reset enters (0,0) and fires Frame_Start_Sig.
- Enable:
  - Enable is sampled on Pix_En ticks.
  - While Enable=0, counters are held at (H_TOTAL-1, V_TOTAL-1) and all outputs are at their reset values.
  - The first Pix_En tick with Enable=1 starts a clean frame at (0,0).
  - Deasserting Enable mid-frame aborts the frame on the next Pix_En tick.
- Strobes:
  - Line_Start_Sig and Frame_Start_Sig are high for exactly one CLK, even if Pix_En stays high.
  - Frame_Start_Sig implies Line_Start_Sig in the same cycle.

## Timing
- Latency: output changes appear on the same CLK edge that advances the counters (1 CLK after a Pix_En sample).
- When Pix_En=0, every output holds its value except the strobes, which are 0.
- Reset assertion at any time forces reset values immediately (asynchronously).
- Reset deassertion takes effect at the next CLK edge.
- Frame period is H_TOTAL*V_TOTAL Pix_En ticks. Pix_En may be tied to 1.

## Configuration
- VGA_TIMING_LOOKAHEAD_EN defined:
  - Column_Addr_Sig and Row_Addr_Sig lead Ready_Sig by exactly one Pix_En tick, to cover the read latency of a 1-cycle synchronous RAM.
  - The address for pixel (0,0) is presented one tick before the first Ready_Sig=1.
  - Addresses return to 0 one tick before Ready_Sig falls.
- Undefined: addresses are aligned with Ready_Sig.
- Sync outputs and strobes are unaffected in both cases.

## Test plan
- Reset then Pix_En=1, Enable=1, defaults:
  - Frame_Start_Sig pulses in the first cycle.
  - HSYNC is low for 128 cycles, then high for 928.
  - Line_Start_Sig period is 1056 cycles.
  - Frame_Start_Sig period is 663168 cycles.
- Defaults:
  - Ready_Sig rises on line v=27 at h=216 with Column_Addr_Sig=0, Row_Addr_Sig=0.
  - The last active pixel is h=1015, v=626 with addresses 799/599.
  - Addresses are 0 elsewhere.
- Pix_En toggling 1-of-2: all periods double, strobes remain 1 CLK wide, and outputs hold between ticks.
- Enable dropped at v=300: on the next tick, outputs go to reset values and counters park. On re-enable, Frame_Start_Sig fires and h=v=0.
- HS_POL=1, VS_POL=1, 640x480 parameters (96/48/640/16, 2/33/480/10):
  - HSYNC is high for 96 of 800 cycles.
  - VSYNC is high for 2 of 525 lines.
- With VGA_TIMING_LOOKAHEAD_EN: Column_Addr_Sig=1 coincides with the first Ready_Sig=1, and the address sequence leads by one tick.
